// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller and its PWM output stage.
//   PID_D_WIDTH  - default controller data width (signed duty width)
//   pwm_state_t  - dead-time FSM state encoding
//   sat_abs()    - |v| saturated to a limit; the most-negative input does not wrap
package pid_pkg;

    localparam int PID_D_WIDTH = 18;

    typedef enum logic [2:0] {
        SAFE,
        LO_ON,
        DEAD_R,
        HI_ON,
        DEAD_F
    } pwm_state_t;

    // Callers sign-extend to 32 bits. The magnitude is formed in 33 bits so
    // that -2**31 still yields a positive result before the clamp.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] v,
                                            input logic [31:0]        limit);
        logic [32:0] m;
        m = v[31] ? ({1'b0, ~v} + 33'd1) : {1'b0, v};
        return (m > {1'b0, limit}) ? limit : m[31:0];
    endfunction

endpackage

// File: rtl/pwm_deadband.sv
// Complementary gate generator with dead-time insertion.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   raw           - ungapped PWM request (1 = high side wanted)
//   pwm_en        - 0 forces SAFE (both gates off) on the next cycle
//   force_off     - direction reversal at a period boundary; kicks HI_ON into DEAD_F
//   gate_hi/lo    - registered gate drives, never both high
module pwm_deadband
    import pid_pkg::*;
#(
    parameter int DEAD = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic pwm_en,
    input  logic force_off,
    output logic gate_hi,
    output logic gate_lo
);

    localparam int             DW    = (DEAD < 2) ? 1 : $clog2(DEAD);
    localparam logic [DW-1:0]  DLAST = DW'(DEAD - 1);

    pwm_state_t    state, nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          done;

    assign done = (dcnt == DLAST);

    // dcnt_nxt defaults to zero, so every entry into a timed state starts a
    // fresh DEAD-cycle interval.
    always_comb begin
        nxt      = state;
        dcnt_nxt = '0;
        if (!pwm_en) begin
            nxt = SAFE;
        end else if (force_off && state == HI_ON) begin
            nxt = DEAD_F;
        end else begin
            case (state)
                SAFE: begin
                    if (done) nxt = LO_ON;
                    else      dcnt_nxt = dcnt + 1'b1;
                end
                LO_ON: begin
                    if (raw) nxt = DEAD_R;
                end
                HI_ON: begin
                    if (!raw) nxt = DEAD_F;
                end
                DEAD_R, DEAD_F: begin
                    // Re-sample raw after the gap: a pulse shorter than DEAD
                    // simply returns to the state it came from.
                    if (done) nxt = raw ? HI_ON : LO_ON;
                    else      dcnt_nxt = dcnt + 1'b1;
                end
                default: nxt = SAFE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SAFE;
            dcnt    <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state   <= nxt;
            dcnt    <= dcnt_nxt;
            gate_hi <= (nxt == HI_ON);
            gate_lo <= (nxt == LO_ON);
        end
    end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// PWM output stage for the PID loop: signed duty -> half-bridge gates + direction.
// Duty is double-buffered (shadow -> active at the period boundary).
// Optional macro PWM_CENTER_ALIGNED_EN selects an up/down triangle counter;
// undefined gives an edge-aligned sawtooth.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   pwm_en         - 0 forces both gates off
//   duty_in        - signed duty command, captured on duty_valid
//   duty_valid     - one-cycle capture strobe
//   gate_hi/lo     - gate drives with dead-time
//   dir            - 1 = negative command in force
//   period_start   - high during the cycle the counter sits at the bottom
//   active_mag     - duty magnitude currently in force
module pwm_deadtime_gen
    import pid_pkg::*;
#(
    parameter int D_WIDTH   = PID_D_WIDTH,
    parameter int CNT_WIDTH = 13,
    parameter int PERIOD    = 4096,
    parameter int DEAD      = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pwm_en,
    input  logic signed [D_WIDTH-1:0] duty_in,
    input  logic                      duty_valid,
    output logic                      gate_hi,
    output logic                      gate_lo,
    output logic                      dir,
    output logic                      period_start,
    output logic [CNT_WIDTH:0]        active_mag
);

    localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_WIDTH'(PERIOD - 1);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 wrap;
    logic [CNT_WIDTH:0]   mag_in, shadow_mag;
    logic                 dir_in, shadow_dir, new_dir;
    logic                 raw, force_off;

    assign mag_in = (CNT_WIDTH+1)'(sat_abs(32'(duty_in), 32'(PERIOD)));
    assign dir_in = duty_in[D_WIDTH-1];

`ifdef PWM_CENTER_ALIGNED_EN
    logic up;

    // Triangle 0..PERIOD-1..0; the bottom turn is the only load point.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            up  <= 1'b1;
        end else if (up) begin
            if (cnt == CNT_TOP) begin
                up  <= 1'b0;
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            if (cnt == CNT_WIDTH'(1)) up <= 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    assign wrap = !up && (cnt == CNT_WIDTH'(1));
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= wrap ? '0 : cnt + 1'b1;
    end

    assign wrap = (cnt == CNT_TOP);
`endif

    // A strobe landing on the wrap cycle bypasses the shadow so it takes
    // effect in the period that is just starting.
    assign new_dir   = duty_valid ? dir_in : shadow_dir;
    assign force_off = wrap && (new_dir != dir);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_mag   <= '0;
            shadow_dir   <= 1'b0;
            active_mag   <= '0;
            dir          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (duty_valid) begin
                shadow_mag <= mag_in;
                shadow_dir <= dir_in;
            end
            if (wrap) begin
                active_mag <= duty_valid ? mag_in : shadow_mag;
                dir        <= new_dir;
            end
        end
    end

    assign raw = ({1'b0, cnt} < active_mag);

    pwm_deadband #(
        .DEAD(DEAD)
    ) u_deadband (
        .clock    (clock),
        .reset    (reset),
        .raw      (raw),
        .pwm_en   (pwm_en),
        .force_off(force_off),
        .gate_hi  (gate_hi),
        .gate_lo  (gate_lo)
    );

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen with PERIOD=16, DEAD=2, D_WIDTH=18.
// Stimulus pushes per-cycle expected outputs (hand-derived gate patterns,
// one character per counter value: H=gate_hi, L=gate_lo, -=both off) into a
// queue; a negedge monitor pops and compares.
module tb_pwm_deadtime_gen;

    localparam int D_WIDTH   = 18;
    localparam int CNT_WIDTH = 5;
    localparam int PERIOD    = 16;
    localparam int DEAD      = 2;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      pwm_en = 1'b1;
    logic signed [D_WIDTH-1:0] duty_in = '0;
    logic                      duty_valid = 1'b0;
    logic                      gate_hi, gate_lo, dir, period_start;
    logic [CNT_WIDTH:0]        active_mag;

    pwm_deadtime_gen #(
        .D_WIDTH  (D_WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .PERIOD   (PERIOD),
        .DEAD     (DEAD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pwm_en      (pwm_en),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .gate_hi     (gate_hi),
        .gate_lo     (gate_lo),
        .dir         (dir),
        .period_start(period_start),
        .active_mag  (active_mag)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   t;
        logic hi;
        logic lo;
        logic dir;
        logic ps;
        int   mag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   base  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, t, act, want);
        end
    endtask

    task automatic push_period(input int t0, input string pat, input int mag,
                               input logic d, input logic ps0);
        exp_t e;
        for (int c = 0; c < PERIOD; c++) begin
            e.t   = t0 + c;
            e.hi  = (pat[c] == "H");
            e.lo  = (pat[c] == "L");
            e.dir = d;
            e.ps  = (c == 0) ? ps0 : 1'b0;
            e.mag = mag;
            sb.push_back(e);
        end
    endtask

    // Returns 2 time units into cycle t (cyc always advances, so this ends).
    task automatic wait_cycle(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic issue(input int t, input int v);
        wait_cycle(t);
        duty_in    = D_WIDTH'(v);
        duty_valid = 1'b1;
        @(posedge clock);
        #2;
        duty_valid = 1'b0;
    endtask

    // Monitor: gate overlap every cycle, scoreboard entry when its cycle comes.
    always @(negedge clock) begin
        exp_t e;
        chk("no_overlap", cyc, {31'd0, gate_hi & gate_lo}, 32'd0);
        while (sb.size() > 0 && sb[0].t < cyc) begin
            e = sb.pop_front();
            chk("missed_entry", e.t, 32'(cyc), 32'(e.t));
        end
        if (sb.size() > 0 && sb[0].t == cyc) begin
            e = sb.pop_front();
            chk("gate_hi", cyc, {31'd0, gate_hi}, {31'd0, e.hi});
            chk("gate_lo", cyc, {31'd0, gate_lo}, {31'd0, e.lo});
            chk("dir", cyc, {31'd0, dir}, {31'd0, e.dir});
            chk("period_start", cyc, {31'd0, period_start}, {31'd0, e.ps});
            chk("active_mag", cyc, 32'(active_mag), 32'(e.mag));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        base  = cyc;

        push_period(base +   0, "--LLLLLLLLLLLLLL",  0, 1'b0, 1'b0);
        push_period(base +  16, "LLLLLLLLLLLLLLLL",  0, 1'b0, 1'b1);
        push_period(base +  32, "L--HHHHHH--LLLLL",  8, 1'b0, 1'b1);
        push_period(base +  48, "L--HHHHHHHHHHHHH", 16, 1'b1, 1'b1);
        push_period(base +  64, "HHHHHHHHHHHHHHHH", 16, 1'b1, 1'b1);
        push_period(base +  80, "--LLLLLLLLLLLLLL",  1, 1'b0, 1'b1);
        push_period(base +  96, "L--LLLLLLLLLLLLL",  1, 1'b0, 1'b1);
        push_period(base + 112, "L--HH--LLLLLLLLL",  4, 1'b0, 1'b1);
        push_period(base + 128, "L--H----LLLLLLLL",  4, 1'b0, 1'b1);
        sb.push_back('{t: base + 144, hi: 1'b0, lo: 1'b1, dir: 1'b0, ps: 1'b1, mag: 4});

        issue(base +  16 +  5, 8);
        issue(base +  32 +  5, -20);
        issue(base +  48 +  5, -131072);
        issue(base +  64 +  5, 1);
        issue(base +  96 + 15, 4);       // lands on the wrap cycle

        wait_cycle(base + 128 + 3);      // HI_ON
        pwm_en = 1'b0;
        wait_cycle(base + 128 + 6);
        pwm_en = 1'b1;

        // Counter value 1 of the next period: inside DEAD_R.
        wait_cycle(base + 145);
        chk("pre_reset_gate_hi", cyc, {31'd0, gate_hi}, 32'd0);
        chk("pre_reset_gate_lo", cyc, {31'd0, gate_lo}, 32'd0);
        chk("pre_reset_active_mag", cyc, 32'(active_mag), 32'd4);
        reset = 1'b1;
        #1;
        chk("async_reset_gate_hi", cyc, {31'd0, gate_hi}, 32'd0);
        chk("async_reset_gate_lo", cyc, {31'd0, gate_lo}, 32'd0);
        chk("async_reset_active_mag", cyc, 32'(active_mag), 32'd0);
        chk("async_reset_dir", cyc, {31'd0, dir}, 32'd0);
        chk("async_reset_period_start", cyc, {31'd0, period_start}, 32'd0);

        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        base  = cyc;
        // Shadow was cleared too, so nothing loads at the first wrap.
        push_period(base +  0, "--LLLLLLLLLLLLLL", 0, 1'b0, 1'b0);
        push_period(base + 16, "LLLLLLLLLLLLLLLL", 0, 1'b0, 1'b1);
        wait_cycle(base + 32);

        chk("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream stage of the PID controller. Consumes the signed, saturated controller output and drives one gate-driver half-bridge leg plus a direction line.
- Duty updates are double-buffered and take effect only at period boundaries. High/low gates are complementary with programmable dead-time.
- Emits a period-start strobe; the top level wires it to the controller's iterate strobe so the loop runs once per PWM period.

Parameters:
- D_WIDTH, 18, width of the signed duty input (matches controller data width).
- CNT_WIDTH, 13, width of the period counter; must satisfy PERIOD <= 2**CNT_WIDTH.
- PERIOD, 4096, counts per PWM period; duty magnitude full scale equals PERIOD.
- DEAD, 8, dead-time in clock cycles; must be >= 1 and < PERIOD/2.

Ports:
- clock        in   1          system clock
- reset        in   1          asynchronous, active-high reset
- pwm_en       in   1          1 = switching allowed; 0 = both gates forced off
- duty_in      in   D_WIDTH    signed duty command; sign selects direction, magnitude selects on-time
- duty_valid   in   1          one-cycle strobe; captures duty_in into the shadow register
- gate_hi      out  1          high-side gate drive
- gate_lo      out  1          low-side gate drive
- dir          out  1          1 = negative command; registered
- period_start out  1          one-cycle pulse when the counter is at 0
- active_mag   out  CNT_WIDTH+1  duty magnitude currently in force (debug/observe)

Behaviour:
- Reset (asynchronous, any time, including mid-period or mid-dead-time):
  - cnt=0, shadow_mag=0, shadow_dir=0, active_mag=0, dir=0.
  - gate_hi=0, gate_lo=0, FSM=SAFE, period_start=0.
- Magnitude conversion on duty_valid:
  - mag = |duty_in|, saturated to PERIOD.
  - Most-negative input (-2**(D_WIDTH-1)) saturates to PERIOD; no overflow wrap.
  - shadow_dir = duty_in[D_WIDTH-1].
- Counter:
  - Free-runs 0..PERIOD-1, then wraps to 0.
  - Counts regardless of pwm_en; held at 0 only by reset.
  - period_start is a registered decode of the wrap, so it is high during the cycle cnt==0.
- Shadow load:
  - On the cycle the counter wraps to 0, active_mag<=shadow_mag and dir<=shadow_dir.
  - If duty_valid coincides with that wrap cycle, the incoming value loads straight into active (bypass) and into shadow.
  - A duty_valid mid-period affects only the next period.
- Raw PWM:
  - raw = (cnt < active_mag).
  - mag=0 gives raw always 0. mag=PERIOD gives raw always 1 (100%, no edges).
- Dead-time FSM (states SAFE, LO_ON, DEAD_R, HI_ON, DEAD_F), with dead counter dcnt:
  - SAFE: both gates off; dcnt counts DEAD cycles, then go to LO_ON. Entered on reset and whenever pwm_en=0, from any state, next cycle.
  - LO_ON: gate_lo=1. If raw=1, go to DEAD_R with dcnt cleared.
  - DEAD_R: both off. After DEAD cycles, go to HI_ON if raw=1, else LO_ON.
  - HI_ON: gate_hi=1. If raw=0, go to DEAD_F with dcnt cleared.
  - DEAD_F: both off. After DEAD cycles, go to LO_ON if raw=0, else HI_ON.
- Gate outputs are registered decodes of the next state. gate_hi and gate_lo are never both 1 in any cycle.
- Dead-time steals on-time. A pulse shorter than DEAD collapses: the FSM returns to the original state after the dead interval, both gates off for DEAD cycles.
- Direction change at a boundary: if the new dir differs from the old one and the FSM is in HI_ON, force DEAD_F before HI_ON can be re-entered, so the leg is off for at least DEAD cycles on reversal.

Optional Feature:
- Macro: PWM_CENTER_ALIGNED_EN.
- Defined: counter counts up 0..PERIOD-1, then down to 0 (triangle, period 2*(PERIOD-1) cycles).
  - period_start and the shadow load occur only at the bottom (cnt==0, turning up).
  - raw = (cnt < active_mag) as before, so pulses are centred on cnt==0.
- Undefined: edge-aligned sawtooth as described above. No up/down state is synthesized.

Decomposition:
- pid_pkg holds:
  - D_WIDTH default constant.
  - typedef enum logic [2:0] {SAFE, LO_ON, DEAD_R, HI_ON, DEAD_F} pwm_state_t.
  - A saturating-abs function shared with the controller.
- One sub-module, pwm_deadband: the FSM and dcnt.
  - Inputs: raw, pwm_en, force_off (reversal).
  - Outputs: gate_hi, gate_lo.
- Counter, shadow registers and magnitude conversion live in the top.

Test Plan (bench overrides PERIOD=16, DEAD=2, D_WIDTH=18):
- Reset, pwm_en=1, no duty -> gates off 2 cycles (SAFE), then gate_lo=1 constantly; period_start every 16 cycles; gate_hi never 1.
- duty_in=+8 mid-period -> no change until wrap; next period gate_hi high for 6 cycles, 2-cycle off gaps on both edges, dir=0, active_mag=8.
- duty_in=-20 -> active_mag=16, dir=1, gate_hi continuously high after one DEAD_R; duty_in=-131072 -> active_mag=16, no wrap to 0.
- duty_in=+1 -> pulse shorter than DEAD collapses; gate_hi never asserts, gate_lo drops for 2 cycles per period.
- duty_valid asserted on the wrap cycle with +4 -> the same period shows the 4-count raw window (bypass verified); assert reset mid-DEAD_R -> gates 0 immediately, cnt=0.
- Toggle pwm_en=0 during HI_ON -> both gates 0 next cycle; re-enable -> 2-cycle SAFE, then LO_ON; continuous assertion gate_hi&gate_lo==0 throughout.
